// File: rtl/cascaded_counter_chain.sv
// Chain of STAGES modulo-MODULUS up/down counters under an IDLE/RUN/DONE run controller.
// Optional parallel load is built when PARALLEL_LOAD_EN is defined.
module cascaded_counter_chain #(
    parameter int STAGES  = 3,
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic                      CK,
    input  logic                      RST,
    input  logic                      START,
    input  logic                      STOP,
    input  logic                      FREE,
    input  logic                      UP,
    input  logic                      CLR,
`ifdef PARALLEL_LOAD_EN
    input  logic                      LOAD,
    input  logic [STAGES*WIDTH-1:0]   LOAD_VAL,
`endif
    output logic [STAGES*WIDTH-1:0]   COUNT,
    output logic [STAGES-1:0]         CARRY,
    output logic                      BUSY,
    output logic                      DONE,
    output logic [1:0]                state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] TERM_HI = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ZERO    = '0;
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    state_t                    state_q, state_d;
    logic [STAGES*WIDTH-1:0]   cnt_q, cnt_d;
    logic                      done_q, done_d;

    logic                      cnt_en;
    logic [STAGES-1:0]         carry;
    logic [STAGES*WIDTH-1:0]   cnt_step;
    logic                      load_req;
    logic [STAGES*WIDTH-1:0]   load_cnt;

`ifdef PARALLEL_LOAD_EN
    localparam logic [WIDTH:0] MOD_EXT = (WIDTH+1)'(MODULUS);

    // Out-of-range stage fields are forced to zero so every stage stays inside its modulus.
    always_comb begin
        load_req = LOAD;
        load_cnt = '0;
        for (int i = 0; i < STAGES; i++) begin
            if ({1'b0, LOAD_VAL[i*WIDTH +: WIDTH]} < MOD_EXT) begin
                load_cnt[i*WIDTH +: WIDTH] = LOAD_VAL[i*WIDTH +: WIDTH];
            end
        end
    end
`else
    assign load_req = 1'b0;
    assign load_cnt = '0;
`endif

    // Each stage advances only when every lower stage is enabled and sitting at its terminal.
    always_comb begin
        logic             chain_en;
        logic [WIDTH-1:0] cur;
        cnt_en   = (state_q == ST_RUN) && !CLR && !load_req && !STOP;
        chain_en = cnt_en;
        carry    = '0;
        cnt_step = cnt_q;
        for (int i = 0; i < STAGES; i++) begin
            cur = cnt_q[i*WIDTH +: WIDTH];
            if (chain_en) begin
                if (UP) begin
                    cnt_step[i*WIDTH +: WIDTH] = (cur == TERM_HI) ? ZERO : cur + ONE;
                end else begin
                    cnt_step[i*WIDTH +: WIDTH] = (cur == ZERO) ? TERM_HI : cur - ONE;
                end
            end
            carry[i] = chain_en && (cur == (UP ? TERM_HI : ZERO));
            chain_en = carry[i];
        end
    end

    always_comb begin
        state_d = (state_q == ST_DONE) ? ST_IDLE : state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        if (CLR) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (load_req) begin
            cnt_d = load_cnt;
        end else if (STOP) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (START) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    cnt_d = cnt_step;
                    if (carry[STAGES-1]) begin
                        done_d = 1'b1;
                        if (!FREE) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign COUNT     = cnt_q;
    assign CARRY     = carry;
    assign BUSY      = (state_q == ST_RUN);
    assign DONE      = done_q;
    assign state_dbg = state_q;

endmodule
